rat_intr_source: RTL

// Interrupt-generating peripheral on the RAT MCU port bus: the source end of the MCU's INTR

---
 rtl/rat_intr_source.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rat_intr_source.sv
// RAT MCU interrupt source: a debounced push-button press raises INTR until the ISR acks it with an OUT.
// Optional interrupt mask register, enabled by defining RAT_INTR_MASK_EN.
module rat_intr_source #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter logic [7:0]  ACK_PORT_ID     = 8'h60,
    parameter logic [7:0]  STATUS_PORT_ID  = 8'h61,
    parameter logic [7:0]  COUNT_PORT_ID   = 8'h62,
    parameter logic [7:0]  MASK_PORT_ID    = 8'h63
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_raw_i,
    input  logic [7:0] port_id_i,
    input  logic [7:0] out_port_i,
    input  logic       io_strb_i,
    output logic [7:0] in_data_o,
    output logic       intr_o
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        RISE_CHK  = 2'd1,
        STABLE_HI = 2'd2,
        FALL_CHK  = 2'd3
    } db_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       count_q, count_d;
    logic             btn_s;
    logic             ack;
    logic             mask_bit;

    assign btn_s = sync2_q;
    assign ack   = io_strb_i && (port_id_i == ACK_PORT_ID);

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (btn_s) begin
                    state_d = RISE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            RISE_CHK: begin
                if (!btn_s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!btn_s) begin
                    state_d = FALL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            FALL_CHK: begin
                if (btn_s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // A press arriving together with an ack wins: the request stays pending but overrun is cleared.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        if (press_q) begin
            pending_d = 1'b1;
            overrun_d = ack ? 1'b0 : (overrun_q | pending_q);
            count_d   = count_q + 8'd1;
        end else if (ack) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= 8'h00;
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

`ifdef RAT_INTR_MASK_EN
    logic mask_q, mask_d;
    logic unused_out_bits;

    assign unused_out_bits = ^out_port_i[7:1];
    assign mask_d = (io_strb_i && (port_id_i == MASK_PORT_ID)) ? out_port_i[0] : mask_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= 1'b1;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_bit = mask_q;
    assign intr_o   = pending_q & mask_q;
`else
    logic unused_mask_in;

    assign unused_mask_in = ^{out_port_i, MASK_PORT_ID};
    assign mask_bit       = 1'b0;
    assign intr_o         = pending_q;
`endif

    always_comb begin
        in_data_o = 8'h00;
        if (port_id_i == STATUS_PORT_ID) begin
            in_data_o = {pending_q, overrun_q, level_q, mask_bit, 4'b0000};
        end else if (port_id_i == COUNT_PORT_ID) begin
            in_data_o = count_q;
        end
    end

endmodule
